// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, ALU and response signals for the shared add/sub ALU arbiter.
// master = requesters/ALU/consumer side, slave = arbiter side.
interface alu_share_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_sel;
    logic [NREQ-1:0]   req_ready;
    logic [3:0]        alu_a;
    logic [3:0]        alu_b;
    logic              alu_sel;
    logic [4:0]        alu_c;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [4:0]        rsp_data;
    logic [ID_W-1:0]   rsp_id;
    logic              busy;
    logic [7:0]        op_count;

    modport master (
        output req_valid, req_a, req_b, req_sel, alu_c, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_id, busy, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, alu_c, rsp_ready,
        output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_id, busy, op_count
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external 4-bit add/sub ALU among NREQ requesters.
// One operation at a time: IDLE (grant) -> EXEC (capture ALU result) -> RESP (handshake).
module alu_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);
    localparam int unsigned DW = 4;
    localparam int unsigned RW = 5;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ID_W-1:0]   r_last_grant;
    logic [DW-1:0]     r_alu_a;
    logic [DW-1:0]     r_alu_b;
    logic              r_alu_sel;
    logic              r_rsp_valid;
    logic [RW-1:0]     r_rsp_data;
    logic [ID_W-1:0]   r_rsp_id;
    logic [CW-1:0]     r_op_count;

    logic [ID_W:0]     w_shift;
    logic [2*NREQ-1:0] w_rot;
    logic              w_found;
    logic [ID_W-1:0]   w_winner;
    logic [DW-1:0]     w_a;
    logic [DW-1:0]     w_b;
    logic              w_sel;
    logic [NREQ-1:0]   w_ready;
    logic              w_accept;
    logic              w_exec;
    logic              w_done;

    // Rotate the doubled valid vector so bit 0 is the requester after the last grant
    always_comb begin
        w_shift  = {1'b0, r_last_grant} + (ID_W+1)'(1);
        w_rot    = {bus.req_valid, bus.req_valid} >> w_shift;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found  = 1'b1;
                w_winner = ID_W'((int'(r_last_grant) + 1 + k) % NREQ);
            end
        end
    end

    // Operand mux and one-hot ready for the winner
    always_comb begin
        w_a     = '0;
        w_b     = '0;
        w_sel   = 1'b0;
        w_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_a        = bus.req_a[i*DW +: DW];
                w_b        = bus.req_b[i*DW +: DW];
                w_sel      = bus.req_sel[i];
                w_ready[i] = w_found && (r_state == S_IDLE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_exec   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_accept = 1'b1;
                    w_next   = S_EXEC;
                end
            end
            S_EXEC: begin
                w_exec = 1'b1;
                w_next = S_RESP;
            end
            S_RESP: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ALU operand registers only move on the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= ID_W'(NREQ - 1);
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_winner;
            r_alu_a      <= w_a;
            r_alu_b      <= w_b;
            r_alu_sel    <= w_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_op_count  <= '0;
        end else begin
            if (w_exec) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= bus.alu_c;
                r_rsp_id    <= r_last_grant;
                if (r_op_count != CW'(255)) begin
                    r_op_count <= r_op_count + CW'(1);
                end
            end else if (w_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_sel   = r_alu_sel;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.op_count  = r_op_count;
endmodule
